// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Front-end fetch stage. It owns the program counter and issues sequential,
// word-aligned reads to a synchronous instruction memory that returns data one
// cycle after the request. Returned words are buffered in a 2-entry FIFO and
// presented to decode over a valid/ready handshake. A backend redirect squashes
// every buffered and in-flight fetch and restarts fetching at the target PC.
//
// Parameters:
//   RESET_PC        PC loaded on reset.
//
// Ports:
//   clk             system clock, all state updates on the rising edge
//   reset           synchronous, active-high reset
//   imem_req        read enable to instruction memory this cycle
//   imem_addr       read address, word aligned
//   imem_rdata      read data, valid the cycle after imem_req was high
//   redirect_valid  backend flush/branch redirect (pulse or held)
//   redirect_pc     redirect target, bits [1:0] ignored
//   ready_out       decode can accept this cycle
//   valid_out       instr/pc_out are valid for decode
//   instr           fetched instruction word (FIFO head)
//   pc_out          address of instr
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ready_out,
    output logic        valid_out,
    output logic [31:0] instr,
    output logic [31:0] pc_out
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic        inflight_q;
    logic        inflight_d;
    logic [31:0] inflight_pc_q;
    logic [31:0] inflight_pc_d;
    logic [1:0]  occ_q;
    logic [1:0]  occ_d;
    logic        head_q;
    logic        head_d;
    logic        tail_q;
    logic        tail_d;
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_pc_q    [2];

    // Per-cycle control decisions
    logic        valid_s;
    logic        pop_s;
    logic        push_s;
    logic        issue_s;
    logic [2:0]  pending_s;
    logic [2:0]  limit_s;

    // Handshake, push and issue decisions for the current cycle.
    always_comb begin
        valid_s   = 1'b0;
        pop_s     = 1'b0;
        push_s    = 1'b0;
        issue_s   = 1'b0;
        pending_s = {1'b0, occ_q} + {2'b00, inflight_q};
        limit_s   = 3'd2;
        if (reset) begin
            valid_s = 1'b0;
            pop_s   = 1'b0;
            push_s  = 1'b0;
            issue_s = 1'b0;
        end else if (redirect_valid) begin
            // Redirect squashes everything this cycle: no hand-off, the
            // returning response (if any) is dropped and nothing is issued.
            valid_s = 1'b0;
            pop_s   = 1'b0;
            push_s  = 1'b0;
            issue_s = 1'b0;
        end else begin
            valid_s = (occ_q != 2'd0);
            pop_s   = valid_s && ready_out;
            push_s  = inflight_q;
            // Buffered + outstanding words, less the one leaving now, must
            // stay below capacity so the response always finds a free slot.
            limit_s = 3'd2 + {2'b00, pop_s};
            issue_s = (pending_s < limit_s);
        end
    end

    // Output drive: memory request and the FIFO head toward decode.
    always_comb begin
        imem_req  = issue_s;
        valid_out = valid_s;
        imem_addr = fetch_pc_q;
        instr     = 32'h0000_0000;
        pc_out    = 32'h0000_0000;
        if (reset) begin
            imem_addr = RESET_PC;
            instr     = 32'h0000_0000;
            pc_out    = 32'h0000_0000;
        end else if (occ_q != 2'd0) begin
            instr  = fifo_instr_q[head_q];
            pc_out = fifo_pc_q[head_q];
        end else begin
            instr  = 32'h0000_0000;
            pc_out = 32'h0000_0000;
        end
    end

    // Next-state for PC, in-flight tracking, occupancy and FIFO pointers.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        occ_d         = occ_q;
        head_d        = head_q;
        tail_d        = tail_q;
        if (redirect_valid) begin
            // Reload every cycle the redirect is held; fetch restarts on the
            // first cycle after it drops.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            inflight_d = 1'b0;
            occ_d      = 2'd0;
            head_d     = 1'b0;
            tail_d     = 1'b0;
        end else begin
            if (issue_s) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end else begin
                inflight_d = 1'b0;
            end
            // Simultaneous push and pop leave occupancy unchanged.
            occ_d  = occ_q + {1'b0, push_s} - {1'b0, pop_s};
            head_d = head_q ^ pop_s;
            tail_d = tail_q ^ push_s;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            occ_q         <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            occ_q         <= occ_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    // FIFO storage: the returning word is written at the tail slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_instr_q[i] <= 32'h0000_0000;
                fifo_pc_q[i]    <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_instr_q[tail_q] <= imem_rdata;
            fifo_pc_q[tail_q]    <= inflight_pc_q;
        end else begin
            fifo_instr_q[tail_q] <= fifo_instr_q[tail_q];
            fifo_pc_q[tail_q]    <= fifo_pc_q[tail_q];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. Two instances share the stimulus: one with
// RESET_PC = 0 and one with RESET_PC = 32'hFFFF_FFF8 for PC wrap-around.
// Each instance has a memory model returning 32'hA500_0000 ^ the address of
// the previous cycle's request. Inputs change 1 ns after the rising edge and
// outputs are sampled 2 ns after it.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        req0, valid0, req1, valid1;
    logic [31:0] addr0, rdata0, instr0, pc0;
    logic [31:0] addr1, rdata1, instr1, pc1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut0 (
        .clk(clk), .reset(reset),
        .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ready_out(ready_out), .valid_out(valid0),
        .instr(instr0), .pc_out(pc0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut1 (
        .clk(clk), .reset(reset),
        .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ready_out(ready_out), .valid_out(valid1),
        .instr(instr1), .pc_out(pc1)
    );

    // Synchronous instruction memory models; garbage when not requested.
    always @(posedge clk) begin
        rdata0 <= req0 ? (32'hA500_0000 ^ addr0) : 32'hDEAD_BEEF;
        rdata1 <= req1 ? (32'hA500_0000 ^ addr1) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and apply the inputs for the new cycle.
    task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        reset          = rst;
        ready_out      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    logic [31:0] exp_pc;
    logic [31:0] dut1_pcs [4];
    logic        rdy_r, rv_r;
    logic [31:0] rpc_r;
    int          deliveries;
    int          idle;
    int          max_idle;

    initial begin
        reset          = 1'b1;
        ready_out      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dut1_pcs[0] = 32'hFFFF_FFF8;
        dut1_pcs[1] = 32'hFFFF_FFFC;
        dut1_pcs[2] = 32'h0000_0000;
        dut1_pcs[3] = 32'h0000_0004;

        // ---------------- Reset state and sequential streaming -------------
        do_reset();
        check("rst_req",    {31'd0, req0},   32'd0);
        check("rst_addr0",  addr0,           32'h0000_0000);
        check("rst_addr1",  addr1,           32'hFFFF_FFF8);
        check("rst_valid",  {31'd0, valid0}, 32'd0);
        check("rst_instr",  instr0,          32'h0);
        check("rst_pc",     pc0,             32'h0);

        step(1'b0, 1'b1, 1'b0, 32'h0);  // cycle 0
        check("c0_req",   {31'd0, req0},   32'd1);
        check("c0_addr",  addr0,           32'h0000_0000);
        check("c0_valid", {31'd0, valid0}, 32'd0);
        check("c0_addr1", addr1,           32'hFFFF_FFF8);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // cycle 1
        check("c1_req",   {31'd0, req0},   32'd1);
        check("c1_addr",  addr0,           32'h0000_0004);
        check("c1_valid", {31'd0, valid0}, 32'd0);
        for (int k = 0; k < 4; k++) begin  // cycles 2..5
            step(1'b0, 1'b1, 1'b0, 32'h0);
            check("seq_valid",  {31'd0, valid0}, 32'd1);
            check("seq_pc",     pc0,             32'(4 * k));
            check("seq_instr",  instr0,          32'hA500_0000 | 32'(4 * k));
            check("wrap_valid", {31'd0, valid1}, 32'd1);
            check("wrap_pc",    pc1,             dut1_pcs[k]);
            check("wrap_instr", instr1,          32'hA500_0000 ^ dut1_pcs[k]);
        end

        // ---------------- Back-pressure ------------------------------------
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c0
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c1
        step(1'b0, 1'b0, 1'b0, 32'h0);  // c2: first valid, stalled
        check("bp_c2_valid", {31'd0, valid0}, 32'd1);
        check("bp_c2_req",   {31'd0, req0},   32'd0);
        for (int k = 3; k < 7; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            check("bp_hold_req",   {31'd0, req0}, 32'd0);
            check("bp_hold_pc",    pc0,           32'h0000_0000);
            check("bp_hold_instr", instr0,        32'hA500_0000);
        end
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c7: release
        check("bp_c7_pc",   pc0,           32'h0000_0000);
        check("bp_c7_req",  {31'd0, req0}, 32'd1);
        check("bp_c7_addr", addr0,         32'h0000_0008);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c8
        check("bp_c8_valid", {31'd0, valid0}, 32'd1);
        check("bp_c8_pc",    pc0,             32'h0000_0004);
        check("bp_c8_instr", instr0,          32'hA500_0004);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c9
        check("bp_c9_valid", {31'd0, valid0}, 32'd1);
        check("bp_c9_pc",    pc0,             32'h0000_0008);

        // ---------------- Redirect while streaming (held 2 cycles) ---------
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'h0);  // c0..c3
        step(1'b0, 1'b1, 1'b1, 32'h0000_1003);  // c4
        check("rd_c4_valid", {31'd0, valid0}, 32'd0);
        check("rd_c4_req",   {31'd0, req0},   32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_2001);  // c5: held, new target
        check("rd_c5_valid", {31'd0, valid0}, 32'd0);
        check("rd_c5_req",   {31'd0, req0},   32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c6
        check("rd_c6_req",   {31'd0, req0},   32'd1);
        check("rd_c6_addr",  addr0,           32'h0000_2000);
        check("rd_c6_valid", {31'd0, valid0}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c7
        check("rd_c7_valid", {31'd0, valid0}, 32'd0);
        check("rd_c7_addr",  addr0,           32'h0000_2004);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c8
        check("rd_c8_valid", {31'd0, valid0}, 32'd1);
        check("rd_c8_pc",    pc0,             32'h0000_2000);
        check("rd_c8_instr", instr0,          32'hA500_2000);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c9
        check("rd_c9_pc",    pc0,             32'h0000_2004);

        // ---------------- Redirect pulse with a full FIFO ------------------
        step(1'b0, 1'b0, 1'b0, 32'h0);  // c10
        step(1'b0, 1'b0, 1'b0, 32'h0);  // c11: FIFO full
        check("rf_c11_req", {31'd0, req0}, 32'd0);
        check("rf_c11_pc",  pc0,           32'h0000_2008);
        step(1'b0, 1'b1, 1'b1, 32'h0000_1003);  // c12
        check("rf_c12_valid", {31'd0, valid0}, 32'd0);
        check("rf_c12_req",   {31'd0, req0},   32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c13
        check("rf_c13_addr",  addr0,           32'h0000_1000);
        check("rf_c13_req",   {31'd0, req0},   32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c14
        check("rf_c14_valid", {31'd0, valid0}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c15
        check("rf_c15_valid", {31'd0, valid0}, 32'd1);
        check("rf_c15_pc",    pc0,             32'h0000_1000);
        check("rf_c15_instr", instr0,          32'hA500_1000);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c16
        check("rf_c16_pc",    pc0,             32'h0000_1004);

        // ---------------- Reset mid-stream with full FIFO ------------------
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c0
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c1
        step(1'b0, 1'b0, 1'b0, 32'h0);  // c2
        step(1'b0, 1'b0, 1'b0, 32'h0);  // c3: FIFO full
        step(1'b1, 1'b1, 1'b0, 32'h0);  // reset for one cycle
        check("mr_rst_valid", {31'd0, valid0}, 32'd0);
        check("mr_rst_req",   {31'd0, req0},   32'd0);
        check("mr_rst_pc",    pc0,             32'h0);
        check("mr_rst_instr", instr0,          32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c0'
        check("mr_c0_valid", {31'd0, valid0}, 32'd0);
        check("mr_c0_req",   {31'd0, req0},   32'd1);
        check("mr_c0_addr",  addr0,           32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c1'
        check("mr_c1_valid", {31'd0, valid0}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);  // c2'
        check("mr_c2_valid", {31'd0, valid0}, 32'd1);
        check("mr_c2_pc",    pc0,             32'h0000_0000);

        // ---------------- Random ready / redirect scoreboard ---------------
        do_reset();
        exp_pc     = 32'h0000_0000;
        deliveries = 0;
        idle       = 0;
        max_idle   = 0;
        for (int c = 0; c < 1000; c++) begin
            rdy_r = 1'($urandom_range(0, 1));
            rv_r  = ($urandom_range(0, 19) == 0);
            rpc_r = $urandom;
            step(1'b0, rdy_r, rv_r, rpc_r);
            if (rv_r) begin
                check("rnd_redir_valid", {31'd0, valid0}, 32'd0);
                exp_pc = {rpc_r[31:2], 2'b00};
                idle   = 0;
            end else if (valid0 && rdy_r) begin
                check("rnd_pc",    pc0,    exp_pc);
                check("rnd_instr", instr0, 32'hA500_0000 ^ exp_pc);
                exp_pc = exp_pc + 32'd4;
                deliveries++;
                idle = 0;
            end else if (rdy_r && !valid0) begin
                idle++;
                if (idle > max_idle) max_idle = idle;
            end
        end
        check("rnd_progress", {31'd0, deliveries > 100}, 32'd1);
        check("rnd_max_idle", {31'd0, max_idle <= 8},    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule
